lsu_subword_rmw: RTL and testbench
==================================

Name: lsu_subword_rmw

Overview:
- Load/store unit between the core's memory stage and the word-only data RAM. The RAM has no byte enables.
- Loads: selects, aligns and sign/zero-extends byte, halfword or word data, single cycle.
- Word stores: single cycle, passed straight through.
- Byte and halfword stores: two-cycle read-modify-write, with a stall to the core.
- Misaligned and illegal accesses are blocked and their address is logged in sticky fault registers.

Parameters:
- AW, 10, byte-address width; matches the data RAM address width.
- DW, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  core memory request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data, right-aligned
- load_data  out  DW  extended load result
- stall  out  1  core must hold its request and PC while high
- mem_addr  out  AW  to RAM address
- mem_we  out  1  to RAM write enable
- mem_wdata  out  DW  to RAM write data
- mem_rdata  in  DW  from RAM, combinational read of mem_addr
- fault_valid  out  1  sticky: a misaligned or illegal access occurred
- fault_addr  out  AW  address of the first fault since the last clear
- fault_clr  in  1  synchronous clear of fault_valid and fault_addr

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Reset values:
  - state = IDLE.
  - rmw_buf = 0, lat_addr = 0, lat_wdata = 0, lat_f3 = 0.
  - fault_valid = 0, fault_addr = 0.
  - Consequently mem_we = 0 and stall = 0 until a request arrives.
- Access legality, decoded from req_funct3 and req_addr:
  - Illegal funct3 (011, 110, 111) = fault.
  - Halfword with addr[0] = 1 = fault.
  - Word with addr[1:0] != 0 = fault.
  - Loads use B/H/W/BU/HU; stores use only B/H/W, so store funct3 100/101 = fault.
- Faulting request:
  - mem_we = 0, load_data = 0, stall = 0.
  - At the clock edge, if fault_valid = 0: fault_valid <= 1 and fault_addr <= req_addr. Later faults do not overwrite.
  - fault_clr has priority over a new fault in the same cycle.
- FSM has two states, IDLE and RMW_WR.
- IDLE:
  - mem_addr = req_addr.
  - Load: mem_we = 0, stall = 0.
    - Byte k = addr[1:0]; halfword h = addr[1].
    - load_data = lane extended: sign-extended for B/H, zero-extended for BU/HU, full word for W.
  - Word store: mem_we = 1, mem_wdata = req_wdata, stall = 0; stays in IDLE.
  - Byte/half store, legal:
    - mem_we = 0, stall = 1.
    - At the edge: rmw_buf <= mem_rdata; lat_addr, lat_wdata, lat_f3 <= request; go to RMW_WR.
  - With req_valid = 0: mem_we = 0, stall = 0, load_data = don't-care (drive 0).
- RMW_WR:
  - mem_addr = lat_addr, mem_we = 1, stall = 0.
  - mem_wdata = rmw_buf with the addressed lane replaced. Little-endian:
    - Byte k occupies bits [8k+7:8k], taken from lat_wdata[7:0].
    - Halfword occupies bits [16h+15:16h], taken from lat_wdata[15:0].
  - The core's request, still presented this cycle, is ignored (not re-decoded, no fault logged).
  - Next state is IDLE unconditionally.
- Sub-word store latency: 2 cycles, one stall cycle. Loads and word stores: 0 stall cycles.
- Back-to-back requests:
  - A request following an RMW in the cycle after RMW_WR starts normally.
  - An RMW read in IDLE sees the RAM contents written on the previous edge.
- Reset asserted in RMW_WR: state goes to IDLE asynchronously, mem_we drops immediately, the pending write is lost.
- mem_addr and mem_wdata are don't-care while mem_we = 0, except that mem_addr must equal req_addr in IDLE for load data.

Test Plan:
- Word store then loads:
  - sw 0x80F0_7F81 @0x10 (mem_we = 1, no stall).
  - lb @0x10 -> 0xFFFF_FF81.
  - lbu @0x10 -> 0x0000_0081.
  - lh @0x12 -> 0xFFFF_80F0.
  - lhu @0x12 -> 0x0000_80F0.
  - lw @0x10 -> 0x80F0_7F81.
- Byte RMW:
  - Memory word @0x20 = 0x1122_3344; sb 0xAB @0x22.
  - Cycle 1: stall = 1, mem_we = 0.
  - Cycle 2: mem_we = 1, mem_wdata = 0x11AB_3344, stall = 0.
  - Then lw @0x20 -> 0x11AB_3344.
- Halfword RMW, back-to-back:
  - sh 0xBEEF @0x20, then sh 0xDEAD @0x22, held per stall.
  - Two 2-cycle sequences; final lw @0x20 -> 0xDEAD_BEEF.
- Misaligned:
  - lw @0x21 -> load_data = 0, no stall; fault_valid = 1, fault_addr = 0x21.
  - Then sh @0x33 -> mem_we = 0, fault_addr stays 0x21.
  - fault_clr -> fault_valid = 0, fault_addr = 0.
- Illegal funct3:
  - Store with funct3 = 100 @0x40 -> no write; fault_valid = 1, fault_addr = 0x40.
  - Load with funct3 = 111 -> fault.
- Reset mid-RMW:
  - Assert rst during the RMW_WR cycle of sb @0x24 -> mem_we = 0 immediately; word @0x24 unchanged by the LSU; stall = 0; state IDLE after release.

Source files
------------

// File: rtl/lsu_subword_rmw.sv
// Load/store unit between the memory stage and a word-only data RAM.
// Loads are aligned and extended in a single cycle. Word stores pass straight
// through to the RAM. Byte and halfword stores use a two-cycle
// read-modify-write and stall the core for one cycle. Misaligned or illegal
// accesses are blocked, and the first one since the last clear is logged in
// sticky fault registers.
module lsu_subword_rmw #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic [DW-1:0] load_data,
    output logic          stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          fault_valid,
    output logic [AW-1:0] fault_addr,
    input  logic          fault_clr
);

    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] rmw_buf;
    logic [AW-1:0] lat_addr;
    // A sub-word merge only ever needs the low halfword of the store data
    logic [15:0]   lat_wdata;
    logic [2:0]    lat_f3;

    logic          legal;
    logic          fault;
    logic          start_rmw;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [DW-1:0] merged;

    // Decode access legality from funct3 and address alignment
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~req_addr[0];
            3'b010:  legal = (req_addr[1:0] == 2'b00);
            3'b100:  legal = ~req_we;
            3'b101:  legal = ~req_we & ~req_addr[0];
            default: legal = 1'b0;
        endcase
        fault     = req_valid & ~legal & (state == IDLE);
        start_rmw = req_valid & legal & req_we & (req_funct3 != 3'b010) & (state == IDLE);
    end

    // Select the addressed byte and halfword lanes of the RAM read data
    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (req_addr[1:0])
            2'b00:   byte_lane = mem_rdata[7:0];
            2'b01:   byte_lane = mem_rdata[15:8];
            2'b10:   byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Replace the latched lane of the buffered word with the new store data
    always_comb begin
        merged = rmw_buf;
        if (lat_f3 == 3'b001) begin
            if (lat_addr[1]) merged[31:16] = lat_wdata;
            else             merged[15:0]  = lat_wdata;
        end else begin
            case (lat_addr[1:0])
                2'b00:   merged[7:0]   = lat_wdata[7:0];
                2'b01:   merged[15:8]  = lat_wdata[7:0];
                2'b10:   merged[23:16] = lat_wdata[7:0];
                default: merged[31:24] = lat_wdata[7:0];
            endcase
        end
    end

    // Next-state and output logic for the two-state RMW sequencer
    always_comb begin
        state_next = state;
        mem_addr   = req_addr;
        mem_we     = 1'b0;
        mem_wdata  = req_wdata;
        stall      = 1'b0;
        load_data  = '0;
        case (state)
            IDLE: begin
                if (req_valid && legal) begin
                    if (!req_we) begin
                        case (req_funct3)
                            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
                            3'b100:  load_data = {24'b0, byte_lane};
                            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
                            3'b101:  load_data = {16'b0, half_lane};
                            default: load_data = mem_rdata;
                        endcase
                    end else if (req_funct3 == 3'b010) begin
                        mem_we = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_next = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_addr   = lat_addr;
                mem_we     = 1'b1;
                mem_wdata  = merged;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any pending RMW write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture the read word and the request when a sub-word store starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rmw_buf   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_f3    <= '0;
        end else if (start_rmw) begin
            rmw_buf   <= mem_rdata;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata[15:0];
            lat_f3    <= req_funct3;
        end
    end

    // Sticky fault log: clear wins, otherwise only the first fault is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
        end else if (fault_clr) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
        end else if (fault && !fault_valid) begin
            fault_valid <= 1'b1;
            fault_addr  <= req_addr;
        end
    end

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Self-checking bench for lsu_subword_rmw: directed scenarios plus randomized
// traffic compared against a byte-addressed memory and fault-log model.
module tb_lsu_subword_rmw;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] load_data;
    logic          stall;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          fault_valid;
    logic [AW-1:0] fault_addr;
    logic          fault_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:255];
    logic [7:0]  ref_mem [0:1023];
    bit          rf_valid = 1'b0;
    logic [9:0]  rf_addr = '0;

    lsu_subword_rmw #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .load_data(load_data), .stall(stall),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    // Word-only RAM: combinational read, write on the rising edge
    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit is_legal(input logic we, input logic [2:0] f3, input logic [9:0] addr);
        int sz = size_of(f3);
        if (sz == 0) return 1'b0;
        if (we && f3[2]) return 1'b0;
        return (int'(addr) % sz) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [9:0] addr);
        int sz = size_of(f3);
        logic [31:0] v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
        if (sz < 4 && !f3[2] && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic model_access(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                                input logic [31:0] wdata);
        logic [31:0] d = wdata;
        if (!is_legal(we, f3, addr)) begin
            if (!rf_valid) begin
                rf_valid = 1'b1;
                rf_addr  = addr;
            end
        end else if (we) begin
            for (int i = 0; i < size_of(f3); i++) begin
                ref_mem[int'(addr) + i] = d[7:0];
                d = d >> 8;
            end
        end
    endtask

    // Present one request and hold it while stall is high (no comparisons here)
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                           input logic [31:0] wdata, output logic [31:0] ld,
                           output int stalls, output bit wrote, output bit hung);
        logic s;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        ld = '0; stalls = 0; wrote = 1'b0; hung = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) ld = load_data;
            if (mem_we) wrote = 1'b1;
            s = stall;
            @(posedge clk); #1;
            if (s) stalls++;
            else begin
                hung = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
        model_access(we, f3, addr, wdata);
    endtask

    task automatic pulse_clear();
        fault_clr = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        rf_valid = 1'b0;
        rf_addr  = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (fault_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault_valid: got %b expected 0", fault_valid); end
        checks++; if (fault_addr !== 10'h000) begin errors++; $display("[TB] FAIL reset_fault_addr: got %h expected 000", fault_addr); end
    endtask

    task automatic init_mem();
        logic [31:0] ld; int st; bit wr, hg;
        for (int w = 0; w < 256; w++) run_req(1'b1, 3'b010, 10'(w * 4), $urandom, ld, st, wr, hg);
    endtask

    task automatic test_word_then_loads();
        logic [31:0] ld; int st; bit wr, hg;
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [9:0]  ads  [5] = '{10'h10, 10'h10, 10'h12, 10'h12, 10'h10};
        logic [31:0] exps [5] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_80F0, 32'h0000_80F0, 32'h80F0_7F81};
        run_req(1'b1, 3'b010, 10'h10, 32'h80F0_7F81, ld, st, wr, hg);
        checks++; if (wr !== 1'b1) begin errors++; $display("[TB] FAIL sw_mem_we: got %b expected 1", wr); end
        checks++; if (st != 0 || hg) begin errors++; $display("[TB] FAIL sw_stall: got %0d stalls expected 0", st); end
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3s[i], ads[i], '0, ld, st, wr, hg);
            checks++;
            if (ld !== exps[i] || st != 0 || hg)
                begin errors++; $display("[TB] FAIL load_%0d: got %h stalls %0d expected %h stalls 0", i, ld, st, exps[i]); end
        end
    endtask

    task automatic test_byte_rmw();
        logic [31:0] ld; int st; bit wr, hg;
        run_req(1'b1, 3'b010, 10'h20, 32'h1122_3344, ld, st, wr, hg);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 10'h22; req_wdata = 32'h0000_00AB;
        @(negedge clk);
        checks++; if (stall !== 1'b1 || mem_we !== 1'b0)
            begin errors++; $display("[TB] FAIL sb_cycle1: got stall %b we %b expected stall 1 we 0", stall, mem_we); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || stall !== 1'b0 || mem_wdata !== 32'h11AB_3344 || mem_addr !== 10'h22)
            begin errors++; $display("[TB] FAIL sb_cycle2: got we %b stall %b data %h addr %h expected we 1 stall 0 data 11ab3344 addr 022", mem_we, stall, mem_wdata, mem_addr); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_access(1'b1, 3'b000, 10'h22, 32'h0000_00AB);
        run_req(1'b0, 3'b010, 10'h20, '0, ld, st, wr, hg);
        checks++; if (ld !== 32'h11AB_3344) begin errors++; $display("[TB] FAIL sb_readback: got %h expected 11ab3344", ld); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ld; int st1, st2, st; bit wr1, wr2, wr, hg1, hg2, hg;
        run_req(1'b1, 3'b001, 10'h20, 32'h1234_BEEF, ld, st1, wr1, hg1);
        run_req(1'b1, 3'b001, 10'h22, 32'h5678_DEAD, ld, st2, wr2, hg2);
        checks++; if (st1 != 1 || st2 != 1 || hg1 || hg2 || !wr1 || !wr2)
            begin errors++; $display("[TB] FAIL sh_b2b_stalls: got %0d/%0d expected 1/1", st1, st2); end
        run_req(1'b0, 3'b010, 10'h20, '0, ld, st, wr, hg);
        checks++; if (ld !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sh_b2b_readback: got %h expected deadbeef", ld); end
    endtask

    task automatic test_misaligned();
        logic [31:0] ld; int st; bit wr, hg;
        run_req(1'b0, 3'b010, 10'h21, '0, ld, st, wr, hg);
        checks++; if (ld !== 32'h0 || st != 0) begin errors++; $display("[TB] FAIL lw_misaligned: got %h stalls %0d expected 0 stalls 0", ld, st); end
        checks++; if (fault_valid !== 1'b1 || fault_addr !== 10'h21)
            begin errors++; $display("[TB] FAIL fault_first: got %b %h expected 1 021", fault_valid, fault_addr); end
        run_req(1'b1, 3'b001, 10'h33, 32'hFFFF_FFFF, ld, st, wr, hg);
        checks++; if (wr !== 1'b0 || st != 0) begin errors++; $display("[TB] FAIL sh_misaligned_write: got we %b expected 0", wr); end
        checks++; if (fault_addr !== 10'h21) begin errors++; $display("[TB] FAIL fault_sticky: got %h expected 021", fault_addr); end
        pulse_clear();
        checks++; if (fault_valid !== 1'b0 || fault_addr !== 10'h0)
            begin errors++; $display("[TB] FAIL fault_clear: got %b %h expected 0 000", fault_valid, fault_addr); end
    endtask

    task automatic test_clear_priority();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 10'h3E; fault_clr = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; fault_clr = 1'b0;
        checks++; if (fault_valid !== 1'b0 || fault_addr !== 10'h0)
            begin errors++; $display("[TB] FAIL clear_priority: got %b %h expected 0 000", fault_valid, fault_addr); end
    endtask

    task automatic test_illegal_funct3();
        logic [31:0] ld; int st; bit wr, hg;
        run_req(1'b1, 3'b100, 10'h40, 32'hA5A5_A5A5, ld, st, wr, hg);
        checks++; if (wr !== 1'b0 || fault_valid !== 1'b1 || fault_addr !== 10'h40)
            begin errors++; $display("[TB] FAIL store_f3_100: got we %b fault %b %h expected 0 1 040", wr, fault_valid, fault_addr); end
        run_req(1'b0, 3'b010, 10'h40, '0, ld, st, wr, hg);
        checks++; if (ld !== exp_load(3'b010, 10'h40)) begin errors++; $display("[TB] FAIL store_f3_100_mem: got %h expected %h", ld, exp_load(3'b010, 10'h40)); end
        pulse_clear();
        run_req(1'b0, 3'b111, 10'h44, '0, ld, st, wr, hg);
        checks++; if (ld !== 32'h0 || fault_valid !== 1'b1 || fault_addr !== 10'h44)
            begin errors++; $display("[TB] FAIL load_f3_111: got %h fault %b %h expected 0 1 044", ld, fault_valid, fault_addr); end
        pulse_clear();
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] ld; int st; bit wr, hg;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 10'h24; req_wdata = 32'h0000_005A;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_rmw_stall: got %b expected 1", stall); end
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL rst_rmw_wr_phase: got %b expected 1", mem_we); end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("[TB] FAIL rst_async_drop: got we %b stall %b expected 0 0", mem_we, stall); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        rf_valid = 1'b0; rf_addr = '0;
        run_req(1'b0, 3'b010, 10'h24, '0, ld, st, wr, hg);
        checks++; if (ld !== exp_load(3'b010, 10'h24) || st != 0)
            begin errors++; $display("[TB] FAIL rst_word_unchanged: got %h expected %h", ld, exp_load(3'b010, 10'h24)); end
    endtask

    task automatic test_random();
        logic [31:0] ld, wd, el; int st, sz; bit wr, hg, we, lg;
        logic [2:0] f3; logic [9:0] addr; int r;
        logic [2:0] ok_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] bad_f3 [3] = '{3'b011, 3'b110, 3'b111};
        for (int n = 0; n < 150; n++) begin
            if (n % 25 == 24) pulse_clear();
            r    = $urandom_range(0, 11);
            f3   = (r < 10) ? ok_f3[r % 5] : bad_f3[$urandom_range(0, 2)];
            we   = 1'($urandom_range(0, 1));
            addr = 10'($urandom_range(0, 1023));
            sz   = size_of(f3);
            if (sz > 1 && $urandom_range(0, 3) != 0) addr = addr & ~10'(sz - 1);
            wd   = $urandom;
            lg   = is_legal(we, f3, addr);
            el   = (lg && !we) ? exp_load(f3, addr) : 32'h0;
            run_req(we, f3, addr, wd, ld, st, wr, hg);
            checks++; if (hg) begin errors++; $display("[TB] FAIL rnd_hang %0d: stall never dropped", n); end
            if (!we) begin
                checks++; if (ld !== el) begin errors++; $display("[TB] FAIL rnd_load %0d f3 %b addr %h: got %h expected %h", n, f3, addr, ld, el); end
            end
            checks++; if (st != ((lg && we && sz < 4) ? 1 : 0))
                begin errors++; $display("[TB] FAIL rnd_stall %0d: got %0d expected %0d", n, st, (lg && we && sz < 4) ? 1 : 0); end
            checks++; if (wr !== (lg && we)) begin errors++; $display("[TB] FAIL rnd_write %0d: got %b expected %b", n, wr, lg && we); end
            checks++; if (fault_valid !== rf_valid || fault_addr !== rf_addr)
                begin errors++; $display("[TB] FAIL rnd_fault %0d: got %b %h expected %b %h", n, fault_valid, fault_addr, rf_valid, rf_addr); end
        end
        for (int k = 0; k < 32; k++) begin
            addr = 10'($urandom_range(0, 255) * 4);
            run_req(1'b0, 3'b010, addr, '0, ld, st, wr, hg);
            checks++; if (ld !== exp_load(3'b010, addr)) begin errors++; $display("[TB] FAIL rnd_sweep %h: got %h expected %h", addr, ld, exp_load(3'b010, addr)); end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        init_mem();
        test_word_then_loads();
        test_byte_rmw();
        test_back_to_back();
        test_misaligned();
        test_clear_priority();
        test_illegal_funct3();
        test_reset_mid_rmw();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
